// File: rtl/xpb_pkg.sv
// -----------------------------------------------------------------------------
// xpb_pkg
// Shared constants and types for the xpb accumulation block in the
// modular-squaring reduction path.
//   XPB_WIDTH      width of one xpb table term
//   XPB_NUM_TERMS  number of terms summed per reduction
//   XPB_SEG_W      carry-propagate segment width used while resolving
//   XPB_SUM_W      width of the widened partial sum (no bits can be lost)
//   XPB_SEGS       number of resolve segments (top one may be partial)
// -----------------------------------------------------------------------------
package xpb_pkg;

   localparam int XPB_WIDTH     = 1024;
   localparam int XPB_NUM_TERMS = 32;
   localparam int XPB_SEG_W     = 64;
   localparam int XPB_SUM_W     = XPB_WIDTH + $clog2(XPB_NUM_TERMS);
   localparam int XPB_SEGS      = (XPB_SUM_W + XPB_SEG_W - 1) / XPB_SEG_W;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      RESOLVE
   } xpb_accum_state_t;

endpackage

// File: rtl/xpb_accum_csa_3to2.sv
// -----------------------------------------------------------------------------
// csa_3to2
// Purely combinational 3:2 carry-save compressor of parameterised width.
// The carry output is the raw per-bit majority; the caller applies the
// one-bit left shift so it can decide how to treat the top bit.
//   i_a, i_b, i_c  three W-bit operands
//   o_sum          bitwise XOR of the operands
//   o_carry        bitwise majority of the operands (unshifted)
// -----------------------------------------------------------------------------
module csa_3to2 #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [W-1:0] i_c,
   output logic [W-1:0] o_sum,
   output logic [W-1:0] o_carry
);

   // Sum and majority are independent per bit, so no carry chain exists here.
   assign o_sum   = i_a ^ i_b ^ i_c;
   assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/xpb_accum.sv
// -----------------------------------------------------------------------------
// xpb_accum
// Sums NUM_TERMS registered xpb terms in carry-save form, then resolves the
// redundant (sum, carry) pair to binary and presents the widened partial sum
// with a one-cycle valid pulse.
//
// Build option: define XPB_ACCUM_FAST_RESOLVE_EN to resolve in a single cycle
// with a full-width adder; otherwise the resolve walks SEG_W-bit segments,
// one per cycle, rippling the carry between them.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       pulse: clear accumulators and begin (or restart) a reduction
//   term_valid  term carries a valid xpb table output this cycle
//   term        xpb table data_out (WIDTH bits)
//   busy        high from start until out_valid
//   out_valid   one-cycle pulse, result complete
//   result      resolved sum (SUM_W bits), held until the next completed run
// -----------------------------------------------------------------------------
module xpb_accum
   import xpb_pkg::*;
#(
   parameter int WIDTH     = XPB_WIDTH,
   parameter int NUM_TERMS = XPB_NUM_TERMS,
   parameter int SEG_W     = XPB_SEG_W
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  term_valid,
   input  logic [WIDTH-1:0]                      term,
   output logic                                  busy,
   output logic                                  out_valid,
   output logic [WIDTH+$clog2(NUM_TERMS)-1:0]    result
);

   localparam int SUM_W = WIDTH + $clog2(NUM_TERMS);
   localparam int CNT_W = $clog2(NUM_TERMS + 1);

   xpb_accum_state_t r_state;
   xpb_accum_state_t w_nextState;

   logic [SUM_W-1:0] r_sum;
   logic [SUM_W-1:0] r_carry;
   logic [SUM_W-1:0] r_result;
   logic [CNT_W-1:0] r_termCnt;
   logic             r_outValid;

   logic [SUM_W-1:0] w_termExt;
   logic [SUM_W-1:0] w_csaSum;
   logic [SUM_W-1:0] w_csaMaj;
   logic             w_termAccept;
   logic             w_lastTerm;
   logic             w_resolveDone;

   // The term is zero-extended; the widened sum has room for the full total.
   assign w_termExt = SUM_W'(term);

   csa_3to2 #(
      .W (SUM_W)
   ) u_csa (
      .i_a     (r_sum),
      .i_b     (r_carry),
      .i_c     (w_termExt),
      .o_sum   (w_csaSum),
      .o_carry (w_csaMaj)
   );

   // A start in the same cycle always wins, so the coincident term is dropped.
   assign w_termAccept = (r_state == ACCUM) && term_valid && !start;
   assign w_lastTerm   = w_termAccept && (r_termCnt == CNT_W'(NUM_TERMS - 1));

`ifdef XPB_ACCUM_FAST_RESOLVE_EN

   // Single-cycle resolve: the whole redundant pair goes through one adder.
   assign w_resolveDone = (r_state == RESOLVE);

`else

   localparam int SEGS   = (SUM_W + SEG_W - 1) / SEG_W;
   localparam int PAD_W  = SEGS * SEG_W;
   localparam int IDX_W  = (SEGS > 1) ? $clog2(SEGS) : 1;
   localparam int BASE_W = $clog2(PAD_W);

   logic [IDX_W-1:0]  r_segIdx;
   logic              r_cin;

   logic [PAD_W-1:0]  w_sumPad;
   logic [PAD_W-1:0]  w_carryPad;
   logic [BASE_W-1:0] w_segBase;
   logic [SEG_W:0]    w_segAdd;
   logic [SUM_W-1:0]  w_resolved;

   // Zero padding lets the partial top segment use the same adder slice; its
   // extra sum bits and final carry-out simply never land anywhere.
   assign w_sumPad   = PAD_W'(r_sum);
   assign w_carryPad = PAD_W'(r_carry);
   assign w_segBase  = BASE_W'(r_segIdx * SEG_W);
   assign w_segAdd   = {1'b0, w_sumPad[w_segBase +: SEG_W]}
                     + {1'b0, w_carryPad[w_segBase +: SEG_W]}
                     + (SEG_W + 1)'(r_cin);

   // Resolved segments overwrite r_sum in place, so r_result is only written
   // once the whole sum is ready and an aborted resolve leaves it untouched.
   always_comb begin
      w_resolved = r_sum;
      for (int i = 0; i < SUM_W; i++) begin
         if ((i / SEG_W) == int'(r_segIdx)) begin
            w_resolved[i] = w_segAdd[i % SEG_W];
         end
      end
   end

   assign w_resolveDone = (r_state == RESOLVE) && (r_segIdx == IDX_W'(SEGS - 1));

`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: start restarts accumulation from any state.
   always_comb begin
      w_nextState = r_state;
      if (start) begin
         w_nextState = ACCUM;
      end else begin
         case (r_state)
            IDLE:    w_nextState = IDLE;
            ACCUM:   if (w_lastTerm)    w_nextState = RESOLVE;
            RESOLVE: if (w_resolveDone) w_nextState = IDLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   // Datapath: carry-save accumulate, then resolve and publish the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum      <= '0;
         r_carry    <= '0;
         r_termCnt  <= '0;
         r_result   <= '0;
         r_outValid <= 1'b0;
`ifndef XPB_ACCUM_FAST_RESOLVE_EN
         r_segIdx   <= '0;
         r_cin      <= 1'b0;
`endif
      end else begin
         r_outValid <= 1'b0;
         if (start) begin
            r_sum     <= '0;
            r_carry   <= '0;
            r_termCnt <= '0;
`ifndef XPB_ACCUM_FAST_RESOLVE_EN
            r_segIdx  <= '0;
            r_cin     <= 1'b0;
`endif
         end else begin
            case (r_state)
               ACCUM: begin
                  if (w_termAccept) begin
                     r_sum     <= w_csaSum;
                     r_carry   <= w_csaMaj << 1;
                     r_termCnt <= r_termCnt + CNT_W'(1);
`ifndef XPB_ACCUM_FAST_RESOLVE_EN
                     if (w_lastTerm) begin
                        r_segIdx <= '0;
                        r_cin    <= 1'b0;
                     end
`endif
                  end
               end
               RESOLVE: begin
`ifdef XPB_ACCUM_FAST_RESOLVE_EN
                  r_result   <= r_sum + r_carry;
                  r_outValid <= 1'b1;
`else
                  r_sum    <= w_resolved;
                  r_cin    <= w_segAdd[SEG_W];
                  r_segIdx <= r_segIdx + IDX_W'(1);
                  if (w_resolveDone) begin
                     r_result   <= w_resolved;
                     r_outValid <= 1'b1;
                     r_segIdx   <= '0;
                     r_cin      <= 1'b0;
                  end
`endif
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign busy      = (r_state != IDLE);
   assign out_valid = r_outValid;
   assign result    = r_result;

endmodule

// File: tb/tb_xpb_accum.sv
// -----------------------------------------------------------------------------
// tb_xpb_accum
// Directed bench for xpb_accum. Expected sums are queued when a reduction is
// driven and compared whenever the design pulses out_valid.
// -----------------------------------------------------------------------------
module tb_xpb_accum;
   import xpb_pkg::*;

   localparam int WIDTH     = XPB_WIDTH;
   localparam int NUM_TERMS = XPB_NUM_TERMS;
   localparam int SUM_W     = XPB_SUM_W;
`ifdef XPB_ACCUM_FAST_RESOLVE_EN
   localparam int EXP_LAT   = 1;
`else
   localparam int EXP_LAT   = XPB_SEGS;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             term_valid;
   logic [WIDTH-1:0] term;
   logic             busy;
   logic             out_valid;
   logic [SUM_W-1:0] result;

   logic [SUM_W-1:0] expQ[$];
   int               vectors;
   int               miscompares;
   int               pulseCount;

   xpb_accum dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .term_valid (term_valid),
      .term       (term),
      .busy       (busy),
      .out_valid  (out_valid),
      .result     (result)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge, away from the sampling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [SUM_W-1:0] obs,
                              input logic [SUM_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed hi=%h lo=%h, expected hi=%h lo=%h", tag,
                obs[SUM_W-1 -: 64], obs[63:0], exp[SUM_W-1 -: 64], exp[63:0]);
      end
   endtask

   // Scoreboard: every out_valid pulse consumes one queued expected sum.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         pulseCount++;
         vectors++;
         assert (expQ.size() > 0) else begin
            miscompares++;
            $error("FAIL spurious_out_valid: observed pulse with %0d queued, expected a queued result",
                   expQ.size());
         end
         if (expQ.size() > 0) begin
            checkOutput("result", result, expQ.pop_front());
         end
      end
   end

   // Drives one reduction: term 0 = firstVal, term 1 = secondVal, the rest
   // restVal. abortAfter > 0 first runs a partial reduction of all-ones terms
   // that is restarted by a start coinciding with a valid term. holdValid
   // keeps term_valid high with value 7 through resolve and idle. resetMid
   // pulls rst_n while the design is resolving.
   task automatic applyStimulus(input string tag,
                                input logic [WIDTH-1:0] firstVal,
                                input logic [WIDTH-1:0] secondVal,
                                input logic [WIDTH-1:0] restVal,
                                input logic [SUM_W-1:0] expVal,
                                input int abortAfter, input bit holdValid,
                                input bit resetMid);
      int  pulsesBefore;
      int  lat;
      pulsesBefore = pulseCount;
      if (abortAfter > 0) begin
         start = 1'b1; term_valid = 1'b0;
         step();
         start = 1'b0; term_valid = 1'b1; term = '1;
         repeat (abortAfter) step();
      end
      start = 1'b1;
      term_valid = (abortAfter > 0);
      term = '1;
      step();
      checkOutput({tag, "_busy_start"}, SUM_W'(busy), SUM_W'(1));
      if (!resetMid) expQ.push_back(expVal);
      start = 1'b0; term_valid = 1'b1;
      for (int i = 0; i < NUM_TERMS; i++) begin
         term = (i == 0) ? firstVal : ((i == 1) ? secondVal : restVal);
         step();
      end
      if (holdValid) begin
         term = WIDTH'(7);
      end else begin
         term_valid = 1'b0; term = '0;
      end
      if (resetMid) begin
         rst_n = 1'b0;
         #2;
         checkOutput({tag, "_rst_busy"}, SUM_W'(busy), '0);
         checkOutput({tag, "_rst_out_valid"}, SUM_W'(out_valid), '0);
         checkOutput({tag, "_rst_result"}, result, '0);
         step();
         rst_n = 1'b1;
         repeat (EXP_LAT + 3) step();
         checkOutput({tag, "_rst_no_pulse"}, SUM_W'(pulseCount), SUM_W'(pulsesBefore));
         return;
      end
      lat = 0;
      for (int k = 1; k <= EXP_LAT + 8; k++) begin
         step();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      checkOutput({tag, "_latency"}, SUM_W'(lat), SUM_W'(EXP_LAT));
      checkOutput({tag, "_busy_done"}, SUM_W'(busy), '0);
      step();
      checkOutput({tag, "_pulse_width"}, SUM_W'(out_valid), '0);
      repeat (4) step();
      term_valid = 1'b0; term = '0;
      checkOutput({tag, "_result_held"}, result, expVal);
      checkOutput({tag, "_pulse_count"}, SUM_W'(pulseCount), SUM_W'(pulsesBefore + 1));
   endtask

   // Bounds the whole run in case the design never responds.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] zeros;
      logic [WIDTH-1:0] five;
      logic [WIDTH-1:0] one;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [WIDTH-1:0] rc;
      logic [SUM_W-1:0] model;

      vectors = 0; miscompares = 0; pulseCount = 0;
      ones = '1; zeros = '0; five = WIDTH'(5); one = WIDTH'(1);
      rst_n = 1'b0; start = 1'b0; term_valid = 1'b0; term = '0;
      #12;
      checkOutput("reset_busy", SUM_W'(busy), '0);
      checkOutput("reset_out_valid", SUM_W'(out_valid), '0);
      checkOutput("reset_result", result, '0);
      step();
      rst_n = 1'b1;
      step();

      // Terms presented while idle must not start anything.
      term_valid = 1'b1; term = ones;
      repeat (3) step();
      term_valid = 1'b0;
      checkOutput("idle_ignores_terms", SUM_W'(busy), '0);

      applyStimulus("zeros", zeros, zeros, zeros, '0, 0, 1'b0, 1'b0);
      applyStimulus("all_ones", ones, ones, ones,
                    {{(SUM_W-5){1'b1}}, 5'b00000}, 0, 1'b0, 1'b0);
      applyStimulus("carry_ripple", ones, one, zeros,
                    SUM_W'(1) << WIDTH, 0, 1'b0, 1'b0);
      applyStimulus("abort_restart", five, five, five, SUM_W'(160), 10, 1'b0, 1'b0);
      applyStimulus("hold_valid", five, five, five, SUM_W'(160), 0, 1'b1, 1'b0);
      applyStimulus("reset_mid", ones, ones, ones, '0, 0, 1'b0, 1'b1);
      applyStimulus("after_reset", ones, one, zeros,
                    SUM_W'(1) << WIDTH, 0, 1'b0, 1'b0);

      for (int w = 0; w < WIDTH / 32; w++) begin
         ra[w*32 +: 32] = $urandom();
         rb[w*32 +: 32] = $urandom();
         rc[w*32 +: 32] = $urandom();
      end
      model = SUM_W'(ra) + SUM_W'(rb);
      for (int i = 2; i < NUM_TERMS; i++) model = model + SUM_W'(rc);
      applyStimulus("random", ra, rb, rc, model, 0, 1'b0, 1'b0);

      checkOutput("scoreboard_drained", SUM_W'(expQ.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
